// File: rtl/ysyx_22051013_idex_stage.sv
// ID/EX pipeline register: resolves operands with EX/MEM/WB bypass, stalls on load-use / EX-not-ready,
// bubbles on flush, 1-cycle latency, holds out_* while EX is not ready.
module ysyx_22051013_idex_stage #(
  parameter int XLEN   = 64,
  parameter int CTRL_W = 16,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   in_pc,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic              in_ren1,
  input  logic              in_ren2,
  input  logic [4:0]        in_rd,
  input  logic              in_rd_wen,
  input  logic              in_is_load,
  input  logic [XLEN-1:0]   in_imm,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic [4:0]        rf_raddr1,
  output logic [4:0]        rf_raddr2,
  output logic              rf_ren1,
  output logic              rf_ren2,
  input  logic [XLEN-1:0]   rf_rdata1,
  input  logic [XLEN-1:0]   rf_rdata2,
  input  logic              ex_fwd_valid,
  input  logic [XLEN-1:0]   ex_fwd_data,
  input  logic [4:0]        mem_rd,
  input  logic              mem_wen,
  input  logic              mem_is_load,
  input  logic [XLEN-1:0]   mem_data,
  input  logic [4:0]        wb_rd,
  input  logic              wb_wen,
  input  logic [XLEN-1:0]   wb_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_pc,
  output logic [XLEN-1:0]   out_imm,
  output logic [XLEN-1:0]   out_op1,
  output logic [XLEN-1:0]   out_op2,
  output logic [4:0]        out_rd,
  output logic              out_rd_wen,
  output logic              out_is_load,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic            use1, use2;
  logic            ex_m1, ex_m2, mem_m1, mem_m2, wb_m1, wb_m2;
  logic            hazard, capture;
  logic [XLEN-1:0] op1, op2;

  assign rf_raddr1 = in_rs1;
  assign rf_raddr2 = in_rs2;
  assign rf_ren1   = in_ren1;
  assign rf_ren2   = in_ren2;

  assign use1   = in_ren1 & (in_rs1 != 5'd0);
  assign use2   = in_ren2 & (in_rs2 != 5'd0);
  assign ex_m1  = use1 & out_valid & out_rd_wen & (out_rd == in_rs1);
  assign ex_m2  = use2 & out_valid & out_rd_wen & (out_rd == in_rs2);
  assign mem_m1 = use1 & mem_wen & (mem_rd == in_rs1);
  assign mem_m2 = use2 & mem_wen & (mem_rd == in_rs2);
  assign wb_m1  = use1 & wb_wen & (wb_rd == in_rs1);
  assign wb_m2  = use2 & wb_wen & (wb_rd == in_rs2);

  assign hazard   = ((ex_m1 | ex_m2) & (out_is_load | ~ex_fwd_valid))
                  | ((mem_m1 | mem_m2) & mem_is_load);
  assign in_ready = ~flush & ~hazard & (~out_valid | out_ready);
  assign capture  = in_valid & in_ready;

  // Youngest producer wins; WB bypass covers the regfile write landing on this same edge.
  always_comb begin
    op1 = '0;
    if (use1) begin
      if (ex_m1)       op1 = ex_fwd_data;
      else if (mem_m1) op1 = mem_data;
      else if (wb_m1)  op1 = wb_data;
      else             op1 = rf_rdata1;
    end
  end

  always_comb begin
    op2 = '0;
    if (use2) begin
      if (ex_m2)       op2 = ex_fwd_data;
      else if (mem_m2) op2 = mem_data;
      else if (wb_m2)  op2 = wb_data;
      else             op2 = rf_rdata2;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_pc      <= '0;
      out_imm     <= '0;
      out_op1     <= '0;
      out_op2     <= '0;
      out_rd      <= '0;
      out_rd_wen  <= 1'b0;
      out_is_load <= 1'b0;
      out_ctrl    <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (capture) begin
      out_valid   <= 1'b1;
      out_pc      <= in_pc;
      out_imm     <= in_imm;
      out_op1     <= op1;
      out_op2     <= op2;
      out_rd      <= in_rd;
      out_rd_wen  <= in_rd_wen;
      out_is_load <= in_is_load;
      out_ctrl    <= in_ctrl;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (in_valid & hazard & ~flush & (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_ysyx_22051013_idex_stage.sv
// Scenario tests for the ID/EX stage; expected EX-side transactions are queued when driven
// and popped when the stage presents them.
module tb_ysyx_22051013_idex_stage;

  typedef struct packed {
    logic [63:0] pc;
    logic [63:0] imm;
    logic [63:0] op1;
    logic [63:0] op2;
    logic [4:0]  rd;
    logic        rd_wen;
    logic        is_load;
    logic [15:0] ctrl;
  } txn_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid, in_ready;
  logic [63:0] in_pc, in_imm;
  logic [4:0]  in_rs1, in_rs2, in_rd;
  logic        in_ren1, in_ren2, in_rd_wen, in_is_load;
  logic [15:0] in_ctrl;
  logic [4:0]  rf_raddr1, rf_raddr2;
  logic        rf_ren1, rf_ren2;
  logic [63:0] rf_rdata1, rf_rdata2;
  logic        ex_fwd_valid;
  logic [63:0] ex_fwd_data;
  logic [4:0]  mem_rd, wb_rd;
  logic        mem_wen, mem_is_load, wb_wen;
  logic [63:0] mem_data, wb_data;
  logic        flush;
  logic        out_valid, out_ready;
  logic [63:0] out_pc, out_imm, out_op1, out_op2;
  logic [4:0]  out_rd;
  logic        out_rd_wen, out_is_load;
  logic [15:0] out_ctrl;
  logic [31:0] stall_cnt;

  txn_t exp_q[$];
  txn_t got, want, held;
  int   n_checks = 0;
  int   n_fail   = 0;

  ysyx_22051013_idex_stage dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_ren1(in_ren1), .in_ren2(in_ren2),
    .in_rd(in_rd), .in_rd_wen(in_rd_wen), .in_is_load(in_is_load),
    .in_imm(in_imm), .in_ctrl(in_ctrl),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2), .rf_ren1(rf_ren1), .rf_ren2(rf_ren2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .ex_fwd_valid(ex_fwd_valid), .ex_fwd_data(ex_fwd_data),
    .mem_rd(mem_rd), .mem_wen(mem_wen), .mem_is_load(mem_is_load), .mem_data(mem_data),
    .wb_rd(wb_rd), .wb_wen(wb_wen), .wb_data(wb_data),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_imm(out_imm), .out_op1(out_op1), .out_op2(out_op2),
    .out_rd(out_rd), .out_rd_wen(out_rd_wen), .out_is_load(out_is_load),
    .out_ctrl(out_ctrl), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic txn_t mk(input logic [63:0] pc, input logic [63:0] op1, input logic [63:0] op2,
                              input logic [4:0] rd, input logic wen, input logic ld);
    txn_t t;
    t.pc = pc; t.imm = pc ^ 64'hF0F0; t.op1 = op1; t.op2 = op2;
    t.rd = rd; t.rd_wen = wen; t.is_load = ld; t.ctrl = pc[15:0] ^ 16'h5A5A;
    return t;
  endfunction

  function automatic txn_t observed();
    txn_t t;
    t.pc = out_pc; t.imm = out_imm; t.op1 = out_op1; t.op2 = out_op2;
    t.rd = out_rd; t.rd_wen = out_rd_wen; t.is_load = out_is_load; t.ctrl = out_ctrl;
    return t;
  endfunction

  task automatic idle();
    in_valid = 0; in_pc = 0; in_imm = 0; in_ctrl = 0;
    in_rs1 = 0; in_rs2 = 0; in_ren1 = 0; in_ren2 = 0;
    in_rd = 0; in_rd_wen = 0; in_is_load = 0;
    rf_rdata1 = 0; rf_rdata2 = 0;
    ex_fwd_valid = 0; ex_fwd_data = 0;
    mem_rd = 0; mem_wen = 0; mem_is_load = 0; mem_data = 0;
    wb_rd = 0; wb_wen = 0; wb_data = 0;
    flush = 0; out_ready = 1;
  endtask

  task automatic drive_id(input logic [63:0] pc, input logic [4:0] rs1, input logic ren1,
                          input logic [4:0] rs2, input logic ren2,
                          input logic [4:0] rd, input logic wen, input logic ld);
    in_valid = 1; in_pc = pc; in_imm = pc ^ 64'hF0F0; in_ctrl = pc[15:0] ^ 16'h5A5A;
    in_rs1 = rs1; in_ren1 = ren1; in_rs2 = rs2; in_ren2 = ren2;
    in_rd = rd; in_rd_wen = wen; in_is_load = ld;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle();
    rst = 1;
    #2 rst = 0;
    exp_q.delete();
  endtask

  task automatic test_reset();
    idle();
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || stall_cnt !== 32'd0) begin
      n_fail++; $display("FAIL reset_init: valid=%0b stall=%0d required 0/0", out_valid, stall_cnt);
    end
    @(negedge clk); rst = 0;
    @(negedge clk);
    drive_id(64'h100, 5'd3, 1, 5'd0, 0, 5'd4, 1, 0);
    rf_rdata1 = 64'h55; out_ready = 0;
    exp_q.push_back(mk(64'h100, 64'h55, 64'h0, 5'd4, 1, 0));
    @(posedge clk); #1;
    got = observed(); n_checks++;
    if (exp_q.size() == 0) begin n_fail++; $display("FAIL reset_cap: no expected entry"); end
    else begin
      want = exp_q.pop_front();
      if (out_valid !== 1'b1 || got !== want) begin
        n_fail++; $display("FAIL reset_cap: valid=%0b got=%h required=%h", out_valid, got, want);
      end
    end
    @(negedge clk);
    drive_id(64'h104, 5'd4, 1, 5'd0, 0, 5'd1, 1, 0);
    ex_fwd_valid = 0;
    @(posedge clk); #1;
    n_checks++;
    if (stall_cnt !== 32'd1) begin n_fail++; $display("FAIL reset_prestall: stall=%0d required 1", stall_cnt); end
    @(negedge clk);
    rst = 1;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || out_op1 !== 64'h0 || out_pc !== 64'h0 || stall_cnt !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_async: valid=%0b op1=%h pc=%h stall=%0d required all 0", out_valid, out_op1, out_pc, stall_cnt);
    end
    idle();
    #1 rst = 0;
    exp_q.delete();
  endtask

  task automatic test_priority();
    logic [63:0] exp_op[3];
    exp_op[0] = 64'h22; exp_op[1] = 64'h33; exp_op[2] = 64'h44;
    do_reset();
    @(negedge clk);
    drive_id(64'h200, 5'd0, 0, 5'd0, 0, 5'd5, 1, 0);
    exp_q.push_back(mk(64'h200, 64'h0, 64'h0, 5'd5, 1, 0));
    @(posedge clk); #1;
    got = observed(); n_checks++;
    if (exp_q.size() == 0) begin n_fail++; $display("FAIL prio_setup: no expected entry"); end
    else begin
      want = exp_q.pop_front();
      if (out_valid !== 1'b1 || got !== want) begin
        n_fail++; $display("FAIL prio_setup: valid=%0b got=%h required=%h", out_valid, got, want);
      end
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      drive_id(64'h204 + 64'(4 * k), 5'd5, 1, 5'd9, 1, 5'd6, 1, 0);
      ex_fwd_valid = 1; ex_fwd_data = 64'h11;
      mem_rd = 5'd5; mem_wen = (k < 2); mem_is_load = 0; mem_data = 64'h22;
      wb_rd = 5'd5; wb_wen = (k < 3); wb_data = 64'h33;
      rf_rdata1 = 64'h44; rf_rdata2 = 64'h99;
      #1;
      n_checks++;
      if (in_ready !== 1'b1 || {rf_raddr1, rf_raddr2, rf_ren1, rf_ren2} !== {5'd5, 5'd9, 2'b11}) begin
        n_fail++;
        $display("FAIL prio_comb%0d: in_ready=%0b raddr=%0d/%0d ren=%0b%0b required 1 5/9 11", k, in_ready, rf_raddr1, rf_raddr2, rf_ren1, rf_ren2);
      end
      exp_q.push_back(mk(64'h204 + 64'(4 * k), (k == 0) ? 64'h11 : exp_op[k-1], 64'h99, 5'd6, 1, 0));
      @(posedge clk); #1;
      got = observed(); n_checks++;
      if (exp_q.size() == 0) begin n_fail++; $display("FAIL prio_op%0d: no expected entry", k); end
      else begin
        want = exp_q.pop_front();
        if (out_valid !== 1'b1 || got !== want) begin
          n_fail++; $display("FAIL prio_op%0d: op1=%h required=%h got=%h", k, out_op1, want.op1, got);
        end
      end
    end
  endtask

  task automatic test_x0();
    do_reset();
    @(negedge clk);
    drive_id(64'h300, 5'd0, 0, 5'd0, 0, 5'd0, 1, 0);
    exp_q.push_back(mk(64'h300, 64'h0, 64'h0, 5'd0, 1, 0));
    @(posedge clk); #1;
    got = observed(); n_checks++;
    if (exp_q.size() == 0) begin n_fail++; $display("FAIL x0_setup: no expected entry"); end
    else begin
      want = exp_q.pop_front();
      if (out_valid !== 1'b1 || got !== want) begin
        n_fail++; $display("FAIL x0_setup: got=%h required=%h", got, want);
      end
    end
    @(negedge clk);
    drive_id(64'h304, 5'd0, 1, 5'd5, 0, 5'd2, 1, 0);
    ex_fwd_valid = 1; ex_fwd_data = 64'hCC;
    mem_rd = 5'd0; mem_wen = 1; mem_is_load = 1; mem_data = 64'hAA;
    wb_rd = 5'd0; wb_wen = 1; wb_data = 64'hBB;
    rf_rdata1 = 64'hDD; rf_rdata2 = 64'hEE;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL x0_ready: in_ready=%0b required 1", in_ready); end
    exp_q.push_back(mk(64'h304, 64'h0, 64'h0, 5'd2, 1, 0));
    @(posedge clk); #1;
    got = observed(); n_checks++;
    if (exp_q.size() == 0) begin n_fail++; $display("FAIL x0_ops: no expected entry"); end
    else begin
      want = exp_q.pop_front();
      if (out_valid !== 1'b1 || got !== want) begin
        n_fail++; $display("FAIL x0_ops: op1=%h op2=%h required 0/0", out_op1, out_op2);
      end
    end
  endtask

  task automatic test_load_use();
    do_reset();
    @(negedge clk);
    drive_id(64'h400, 5'd0, 0, 5'd0, 0, 5'd7, 1, 1);
    exp_q.push_back(mk(64'h400, 64'h0, 64'h0, 5'd7, 1, 1));
    @(posedge clk); #1;
    got = observed(); n_checks++;
    if (exp_q.size() == 0) begin n_fail++; $display("FAIL lu_load: no expected entry"); end
    else begin
      want = exp_q.pop_front();
      if (out_valid !== 1'b1 || got !== want) begin
        n_fail++; $display("FAIL lu_load: got=%h required=%h", got, want);
      end
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      drive_id(64'h404, 5'd0, 0, 5'd7, 1, 5'd3, 1, 0);
      ex_fwd_valid = 1; ex_fwd_data = 64'hBAD0;
      mem_rd = 5'd7; mem_wen = (k == 1); mem_is_load = 1; mem_data = 64'hBAD1;
      rf_rdata2 = 64'h1234;
      #1;
      n_checks++;
      if (in_ready !== 1'b0) begin n_fail++; $display("FAIL lu_stall%0d: in_ready=%0b required 0", k, in_ready); end
      @(posedge clk); #1;
      n_checks++;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL lu_bubble%0d: out_valid=%0b required 0", k, out_valid); end
    end
    @(negedge clk);
    mem_wen = 0; mem_is_load = 0;
    wb_rd = 5'd7; wb_wen = 1; wb_data = 64'hDEAD;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL lu_release: in_ready=%0b required 1", in_ready); end
    exp_q.push_back(mk(64'h404, 64'h0, 64'hDEAD, 5'd3, 1, 0));
    @(posedge clk); #1;
    got = observed(); n_checks++;
    if (exp_q.size() == 0) begin n_fail++; $display("FAIL lu_capture: no expected entry"); end
    else begin
      want = exp_q.pop_front();
      if (out_valid !== 1'b1 || got !== want) begin
        n_fail++; $display("FAIL lu_capture: op2=%h required=%h got=%h", out_op2, want.op2, got);
      end
    end
    n_checks++;
    if (stall_cnt !== 32'd2) begin n_fail++; $display("FAIL lu_stall_cnt: stall=%0d required 2", stall_cnt); end
  endtask

  task automatic test_backpressure();
    do_reset();
    @(negedge clk);
    drive_id(64'h500, 5'd0, 0, 5'd0, 0, 5'd8, 1, 0);
    held = mk(64'h500, 64'h0, 64'h0, 5'd8, 1, 0);
    exp_q.push_back(held);
    @(posedge clk); #1;
    got = observed(); n_checks++;
    if (exp_q.size() == 0) begin n_fail++; $display("FAIL bp_first: no expected entry"); end
    else begin
      want = exp_q.pop_front();
      if (out_valid !== 1'b1 || got !== want) begin
        n_fail++; $display("FAIL bp_first: got=%h required=%h", got, want);
      end
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      drive_id(64'h504, 5'd1, 1, 5'd2, 1, 5'd9, 1, 0);
      rf_rdata1 = 64'h61; rf_rdata2 = 64'h62; out_ready = 0;
      #1;
      n_checks++;
      if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready%0d: in_ready=%0b required 0", k, in_ready); end
      @(posedge clk); #1;
      got = observed(); n_checks++;
      if (out_valid !== 1'b1 || got !== held) begin
        n_fail++; $display("FAIL bp_hold%0d: valid=%0b got=%h required=%h", k, out_valid, got, held);
      end
    end
    @(negedge clk);
    out_ready = 1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release: in_ready=%0b required 1", in_ready); end
    exp_q.push_back(mk(64'h504, 64'h61, 64'h62, 5'd9, 1, 0));
    @(posedge clk); #1;
    got = observed(); n_checks++;
    if (exp_q.size() == 0) begin n_fail++; $display("FAIL bp_swap: no expected entry"); end
    else begin
      want = exp_q.pop_front();
      if (out_valid !== 1'b1 || got !== want) begin
        n_fail++; $display("FAIL bp_swap: got=%h required=%h", got, want);
      end
    end
    n_checks++;
    if (stall_cnt !== 32'd0) begin n_fail++; $display("FAIL bp_stall_cnt: stall=%0d required 0", stall_cnt); end
  endtask

  task automatic test_flush();
    do_reset();
    @(negedge clk);
    drive_id(64'h600, 5'd0, 0, 5'd0, 0, 5'd8, 1, 0);
    exp_q.push_back(mk(64'h600, 64'h0, 64'h0, 5'd8, 1, 0));
    @(posedge clk); #1;
    got = observed(); n_checks++;
    if (exp_q.size() == 0) begin n_fail++; $display("FAIL fl_setup: no expected entry"); end
    else begin
      want = exp_q.pop_front();
      if (out_valid !== 1'b1 || got !== want) begin
        n_fail++; $display("FAIL fl_setup: got=%h required=%h", got, want);
      end
    end
    @(negedge clk);
    drive_id(64'h604, 5'd8, 1, 5'd0, 0, 5'd3, 1, 0);
    ex_fwd_valid = 0; rf_rdata1 = 64'h71; flush = 1; out_ready = 0;
    #1;
    n_checks++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL fl_ready: in_ready=%0b required 0", in_ready); end
    @(posedge clk); #1;
    n_checks++;
    if (out_valid !== 1'b0 || stall_cnt !== 32'd0) begin
      n_fail++; $display("FAIL fl_squash: valid=%0b stall=%0d required 0/0", out_valid, stall_cnt);
    end
    @(negedge clk);
    flush = 0;
    exp_q.push_back(mk(64'h604, 64'h71, 64'h0, 5'd3, 1, 0));
    @(posedge clk); #1;
    got = observed(); n_checks++;
    if (exp_q.size() == 0) begin n_fail++; $display("FAIL fl_after: no expected entry"); end
    else begin
      want = exp_q.pop_front();
      if (out_valid !== 1'b1 || got !== want) begin
        n_fail++; $display("FAIL fl_after: got=%h required=%h", got, want);
      end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      drive_id(64'h700 + 64'(4 * i), (i == 0) ? 5'd0 : 5'(10 + i - 1), (i != 0), 5'd0, 0, 5'(10 + i), 1, 0);
      ex_fwd_valid = 1; ex_fwd_data = 64'h1000 + 64'(i); rf_rdata1 = 64'hBAD;
      out_ready = 1;
      #1;
      n_checks++;
      if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready%0d: in_ready=%0b required 1", i, in_ready); end
      exp_q.push_back(mk(64'h700 + 64'(4 * i), (i == 0) ? 64'h0 : 64'h1000 + 64'(i), 64'h0, 5'(10 + i), 1, 0));
      @(posedge clk); #1;
      got = observed(); n_checks++;
      if (exp_q.size() == 0) begin n_fail++; $display("FAIL b2b_out%0d: no expected entry", i); end
      else begin
        want = exp_q.pop_front();
        if (out_valid !== 1'b1 || got !== want) begin
          n_fail++; $display("FAIL b2b_out%0d: op1=%h required=%h got=%h", i, out_op1, want.op1, got);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_priority();
    test_x0();
    test_load_use();
    test_backpressure();
    test_flush();
    test_back_to_back();
    @(negedge clk);
    idle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
